// File: rtl/clock_divide_mc_if.sv
// Host register bus for the multi-channel clock divider.
// The host drives the strobes, address and write data.
// The divider returns registered read data.
interface clock_divide_mc_if;
    logic       write;
    logic       read;
    logic [6:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;

    modport master (
        output write,
        output read,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  write,
        input  read,
        input  address,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/clock_divide_mc.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..N-1 and drives a registered divided output and a period tick.
// A new divisor is staged in a shadow register and only becomes active on a period
// boundary, on an enable, or on a sync, so a running period is never cut short.
module clock_divide_mc #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    clock_divide_mc_if.slave        bus,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    localparam logic [DIV_W-1:0] DivOne   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DivTwo   = DIV_W'(2);
    localparam logic [6:0]       SyncAddr = 7'h7F;

    logic [7:0]       stageQ  [NUM_CH];
    logic [7:0]       stageD  [NUM_CH];
    logic [DIV_W-1:0] shadowQ [NUM_CH];
    logic [DIV_W-1:0] shadowD [NUM_CH];
    logic [DIV_W-1:0] divQ    [NUM_CH];
    logic [DIV_W-1:0] divD    [NUM_CH];
    logic [DIV_W-1:0] cntQ    [NUM_CH];
    logic [DIV_W-1:0] cntD    [NUM_CH];

    logic [NUM_CH-1:0] enQ;
    logic [NUM_CH-1:0] enD;
    logic [NUM_CH-1:0] modeQ;
    logic [NUM_CH-1:0] modeD;
    logic [NUM_CH-1:0] clkOutQ;
    logic [NUM_CH-1:0] clkOutD;
    logic [NUM_CH-1:0] tickQ;
    logic [NUM_CH-1:0] tickD;
    logic [NUM_CH-1:0] chHit;
    logic [NUM_CH-1:0] restart;
    logic [NUM_CH-1:0] runNext;

    logic [7:0] readdataQ;
    logic [7:0] readdataD;

    logic [4:0] chanSel;
    logic [1:0] regSel;
    logic       syncWrite;

    assign chanSel   = bus.address[6:2];
    assign regSel    = bus.address[1:0];
    assign syncWrite = bus.write && (bus.address == SyncAddr);

    // Register writes, restart detection, counter stepping and output decode of the next cycle.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            stageD[c]  = stageQ[c];
            shadowD[c] = shadowQ[c];
            enD[c]     = enQ[c];
            modeD[c]   = modeQ[c];
            restart[c] = 1'b0;
            chHit[c]   = bus.write && (chanSel == 5'(c));

            if (chHit[c]) begin
                case (regSel)
                    2'd0: stageD[c] = bus.writedata;
                    2'd1: shadowD[c] = DIV_W'({bus.writedata, stageQ[c]});
                    2'd2: begin
                        enD[c]     = bus.writedata[0];
                        modeD[c]   = bus.writedata[1];
                        restart[c] = bus.writedata[0] && !enQ[c];
                    end
                    default: ;
                endcase
            end

            if (syncWrite && (c < 8) && bus.writedata[3'(c)] && enQ[c]) begin
                restart[c] = 1'b1;
            end

            divD[c] = divQ[c];
            cntD[c] = '0;
            if (enD[c]) begin
                if (restart[c]) begin
                    divD[c] = shadowQ[c];
                end else if (divQ[c] >= DivTwo) begin
                    if (cntQ[c] == divQ[c] - DivOne) begin
                        divD[c] = shadowQ[c];
                    end else begin
                        cntD[c] = cntQ[c] + DivOne;
                    end
                end
            end

            runNext[c] = enD[c] && (divD[c] >= DivTwo);
            tickD[c]   = runNext[c] && (cntD[c] == '0);
            if (modeD[c]) begin
                clkOutD[c] = runNext[c] && (cntD[c] == '0);
            end else begin
                clkOutD[c] = runNext[c] && ({cntD[c], 1'b0} < {1'b0, divD[c]});
            end
        end
    end

    // Read mux sampled from current state, so a same-cycle write is not visible yet.
    always_comb begin
        readdataD = readdataQ;
        if (bus.read) begin
            readdataD = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (chanSel == 5'(c)) begin
                    case (regSel)
                        2'd0: readdataD = 8'(16'(shadowQ[c]));
                        2'd1: readdataD = 8'(16'(shadowQ[c]) >> 8);
                        2'd2: readdataD = {6'd0, modeQ[c], enQ[c]};
                        default: readdataD = {7'd0, enQ[c] && (divQ[c] >= DivTwo)};
                    endcase
                end
            end
        end
    end

    // State register for all channels and the read data, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                stageQ[c]  <= '0;
                shadowQ[c] <= '0;
                divQ[c]    <= '0;
                cntQ[c]    <= '0;
            end
            enQ       <= '0;
            modeQ     <= '0;
            clkOutQ   <= '0;
            tickQ     <= '0;
            readdataQ <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                stageQ[c]  <= stageD[c];
                shadowQ[c] <= shadowD[c];
                divQ[c]    <= divD[c];
                cntQ[c]    <= cntD[c];
            end
            enQ       <= enD;
            modeQ     <= modeD;
            clkOutQ   <= clkOutD;
            tickQ     <= tickD;
            readdataQ <= readdataD;
        end
    end

    assign clk_out      = clkOutQ;
    assign tick         = tickQ;
    assign bus.readdata = readdataQ;

endmodule

// File: tb/tb_clock_divide_mc.sv
// Self-checking bench for clock_divide_mc.
// The reference model tracks each channel as a period start time and a period length,
// and derives outputs from the elapsed time since the period started.
module tb_clock_divide_mc;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clock_divide_mc_if bus ();

    clock_divide_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mStage  [NUM_CH];
    int mShadow [NUM_CH];
    int mEn     [NUM_CH];
    int mMode   [NUM_CH];
    int mN      [NUM_CH];
    int mStart  [NUM_CH];
    int tNow;
    logic [7:0] mRead;

    function automatic void modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            mStage[c] = 0; mShadow[c] = 0; mEn[c] = 0;
            mMode[c] = 0; mN[c] = 0; mStart[c] = 0;
        end
        mRead = 8'd0;
    endfunction

    // Advance the model by one clock given the bus operation presented in this cycle.
    function automatic void modelStep(input logic w, input logic r, input logic [6:0] a,
                                      input logic [7:0] d);
        int ch = int'(a[6:2]);
        int k  = int'(a[1:0]);
        int tNext = tNow + 1;
        if (r) begin
            mRead = 8'd0;
            if (ch < NUM_CH) begin
                case (k)
                    0: mRead = 8'(mShadow[ch] % 256);
                    1: mRead = 8'(mShadow[ch] / 256);
                    2: mRead = 8'(mMode[ch] * 2 + mEn[ch]);
                    default: mRead = (mEn[ch] != 0 && mN[ch] >= 2) ? 8'd1 : 8'd0;
                endcase
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            int oldShadow = mShadow[c];
            int newEn     = mEn[c];
            bit restart   = 1'b0;
            if (w && ch == c) begin
                case (k)
                    0: mStage[c] = int'(d);
                    1: mShadow[c] = (int'(d) * 256 + mStage[c]) % (1 << DIV_W);
                    2: begin
                        restart  = d[0] && (mEn[c] == 0);
                        newEn    = int'(d[0]);
                        mMode[c] = int'(d[1]);
                    end
                    default: ;
                endcase
            end
            if (w && a == 7'h7F && c < 8 && d[c] && mEn[c] != 0) restart = 1'b1;
            if (newEn != 0) begin
                if (restart) begin
                    mStart[c] = tNext;
                    mN[c]     = oldShadow;
                end else if (mN[c] >= 2 && tNext - mStart[c] == mN[c]) begin
                    mStart[c] = tNext;
                    mN[c]     = oldShadow;
                end
            end
            mEn[c] = newEn;
        end
        tNow = tNext;
    endfunction

    function automatic logic [NUM_CH-1:0] expTick();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (mEn[c] != 0 && mN[c] >= 2 && tNow == mStart[c]) v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] expClk();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            int k = tNow - mStart[c];
            if (mEn[c] != 0 && mN[c] >= 2)
                v[c] = (mMode[c] != 0) ? (k == 0) : (2 * k < mN[c]);
        end
        return v;
    endfunction

    // One bus cycle: drive, update the model, then sample just after the edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [6:0] a,
                                 input logic [7:0] d);
        bus.write = w; bus.read = r; bus.address = a; bus.writedata = d;
        modelStep(w, r, a, d);
        @(posedge clk);
        #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.write = 1'b1; bus.read = 1'b0; bus.address = 7'd2; bus.writedata = 8'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; bus.write = 1'b0;
        modelReset();
        tNow = 0;
        checks++; if (clk_out !== '0) begin errors++; $display("[TB] FAIL reset_clk got=%b exp=0", clk_out); end
        checks++; if (tick !== '0) begin errors++; $display("[TB] FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL reset_rd got=%h exp=00", bus.readdata); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 7'(i + 1), 8'd0);
            checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL reset_reg a=%0d got=%h exp=00", i + 1, bus.readdata); end
        end
    endtask

    task automatic test_square();
        logic [3:0] pattern;
        applyStimulus(1'b1, 1'b0, 7'd0, 8'd4);
        applyStimulus(1'b1, 1'b0, 7'd1, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd2, 8'd1);
        pattern = '0;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) pattern[3 - i] = clk_out[0];
            checks++; if (clk_out !== expClk()) begin errors++; $display("[TB] FAIL square_clk t=%0d got=%b exp=%b", tNow, clk_out, expClk()); end
            checks++; if (tick !== expTick()) begin errors++; $display("[TB] FAIL square_tick t=%0d got=%b exp=%b", tNow, tick, expTick()); end
            applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
        end
        checks++; if (pattern !== 4'b1100) begin errors++; $display("[TB] FAIL square_pattern got=%b exp=1100", pattern); end
        applyStimulus(1'b0, 1'b1, 7'd3, 8'd0);
        checks++; if (bus.readdata !== 8'd1) begin errors++; $display("[TB] FAIL status_latency got=%h exp=01", bus.readdata); end
    endtask

    task automatic test_mode_switch();
        applyStimulus(1'b1, 1'b0, 7'd4, 8'd5);
        applyStimulus(1'b1, 1'b0, 7'd5, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd6, 8'd1);
        for (int i = 0; i < 22; i++) begin
            if (i == 11) applyStimulus(1'b1, 1'b0, 7'd6, 8'd3);
            else         applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
            checks++; if (clk_out !== expClk()) begin errors++; $display("[TB] FAIL mode_clk t=%0d got=%b exp=%b", tNow, clk_out, expClk()); end
            checks++; if (tick !== expTick()) begin errors++; $display("[TB] FAIL mode_tick t=%0d got=%b exp=%b", tNow, tick, expTick()); end
        end
    endtask

    task automatic test_div_update();
        int guard = 0;
        int firstTick = -1;
        int gap = -1;
        while (tNow - mStart[0] != 1 && guard < 10) begin
            applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
            guard++;
        end
        checks++; if (tNow - mStart[0] != 1) begin errors++; $display("[TB] FAIL divupd_align k=%0d exp=1", tNow - mStart[0]); end
        for (int i = 0; i < 30; i++) begin
            if (i == 0)       applyStimulus(1'b1, 1'b0, 7'd0, 8'd6);
            else if (i == 1)  applyStimulus(1'b1, 1'b0, 7'd1, 8'd0);
            else if (i == 16) applyStimulus(1'b1, 1'b0, 7'd0, 8'd9);
            else              applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
            if (tick[0]) begin
                if (firstTick < 0) firstTick = i;
                else if (gap < 0) gap = i - firstTick;
            end
            checks++; if (clk_out !== expClk()) begin errors++; $display("[TB] FAIL divupd_clk t=%0d got=%b exp=%b", tNow, clk_out, expClk()); end
            checks++; if (tick !== expTick()) begin errors++; $display("[TB] FAIL divupd_tick t=%0d got=%b exp=%b", tNow, tick, expTick()); end
        end
        checks++; if (firstTick != 2) begin errors++; $display("[TB] FAIL divupd_first got=%0d exp=2", firstTick); end
        checks++; if (gap != 6) begin errors++; $display("[TB] FAIL divupd_gap got=%0d exp=6", gap); end
    endtask

    task automatic test_sync();
        int t0 = 0;
        int both = 0;
        applyStimulus(1'b1, 1'b0, 7'd4, 8'd8);
        applyStimulus(1'b1, 1'b0, 7'd5, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd6, 8'd1);
        applyStimulus(1'b1, 1'b0, 7'd0, 8'd4);
        applyStimulus(1'b1, 1'b0, 7'd1, 8'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'h7F, 8'h03);
        checks++; if (tick[1:0] !== 2'b11) begin errors++; $display("[TB] FAIL sync_align got=%b exp=11", tick[1:0]); end
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
            if (tick[0]) t0++;
            if (tick[1]) both++;
            checks++; if (clk_out !== expClk()) begin errors++; $display("[TB] FAIL sync_clk t=%0d got=%b exp=%b", tNow, clk_out, expClk()); end
            checks++; if (tick !== expTick()) begin errors++; $display("[TB] FAIL sync_tick t=%0d got=%b exp=%b", tNow, tick, expTick()); end
        end
        checks++; if (t0 != 6 || both != 3) begin errors++; $display("[TB] FAIL sync_ratio got=%0d/%0d exp=6/3", t0, both); end
    endtask

    task automatic test_idle_and_unmapped();
        applyStimulus(1'b1, 1'b0, 7'd8, 8'd1);
        applyStimulus(1'b1, 1'b0, 7'd9, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd10, 8'd1);
        applyStimulus(1'b1, 1'b0, 7'd14, 8'd1);
        applyStimulus(1'b1, 1'b0, 7'd16, 8'd1);
        applyStimulus(1'b1, 1'b0, 7'd40, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
            checks++; if (clk_out[3:2] !== 2'b00 || tick[3:2] !== 2'b00) begin errors++; $display("[TB] FAIL idle_out got=%b/%b exp=00/00", clk_out[3:2], tick[3:2]); end
            checks++; if (clk_out !== expClk()) begin errors++; $display("[TB] FAIL idle_clk t=%0d got=%b exp=%b", tNow, clk_out, expClk()); end
        end
        applyStimulus(1'b0, 1'b1, 7'd11, 8'd0);
        checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL idle_status got=%h exp=00", bus.readdata); end
        applyStimulus(1'b0, 1'b1, 7'd6, 8'd0);
        checks++; if (bus.readdata !== 8'd1) begin errors++; $display("[TB] FAIL ctrl_read got=%h exp=01", bus.readdata); end
        applyStimulus(1'b0, 1'b1, 7'h7F, 8'd0);
        checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL sync_read got=%h exp=00", bus.readdata); end
        applyStimulus(1'b0, 1'b1, 7'(4 * NUM_CH), 8'd0);
        checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL unmapped_read got=%h exp=00", bus.readdata); end
        applyStimulus(1'b1, 1'b1, 7'd4, 8'd77);
        checks++; if (bus.readdata !== 8'd8) begin errors++; $display("[TB] FAIL rw_same got=%h exp=08", bus.readdata); end
    endtask

    task automatic test_random();
        logic       w;
        logic       r;
        logic [6:0] a;
        logic [7:0] d;
        int         sel;
        for (int i = 0; i < 500; i++) begin
            sel = int'($urandom_range(0, 15));
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            if (sel < 12)      a = 7'($urandom_range(0, 15));
            else if (sel < 14) a = 7'h7F;
            else               a = 7'($urandom_range(16, 126));
            case (a[1:0])
                2'd0:    d = 8'($urandom_range(0, 12));
                2'd1:    d = ($urandom_range(0, 15) == 0) ? 8'd1 : 8'd0;
                2'd2:    d = 8'($urandom_range(0, 3));
                default: d = 8'($urandom_range(0, 255));
            endcase
            if (a == 7'h7F) d = 8'($urandom_range(0, 255));
            applyStimulus(w, r, a, d);
            checks++; if (clk_out !== expClk()) begin errors++; $display("[TB] FAIL rand_clk t=%0d got=%b exp=%b", tNow, clk_out, expClk()); end
            checks++; if (tick !== expTick()) begin errors++; $display("[TB] FAIL rand_tick t=%0d got=%b exp=%b", tNow, tick, expTick()); end
            checks++; if (bus.readdata !== mRead) begin errors++; $display("[TB] FAIL rand_rd t=%0d got=%h exp=%h", tNow, bus.readdata, mRead); end
        end
    endtask

    task automatic test_reset_midrun();
        applyStimulus(1'b1, 1'b0, 7'd2, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd0, 8'd4);
        applyStimulus(1'b1, 1'b0, 7'd1, 8'd0);
        applyStimulus(1'b1, 1'b0, 7'd2, 8'd1);
        applyStimulus(1'b0, 1'b1, 7'd2, 8'd0);
        checks++; if (clk_out[0] !== 1'b1) begin errors++; $display("[TB] FAIL midrun_pre got=%b exp=1", clk_out[0]); end
        rst = 1'b1;
        bus.write = 1'b1; bus.address = 7'd6; bus.writedata = 8'd1;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.write = 1'b0;
        modelReset();
        checks++; if (clk_out !== '0 || tick !== '0) begin errors++; $display("[TB] FAIL midrun_out got=%b/%b exp=0/0", clk_out, tick); end
        checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL midrun_rd got=%h exp=00", bus.readdata); end
        applyStimulus(1'b0, 1'b1, 7'd2, 8'd0);
        checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL midrun_ctrl0 got=%h exp=00", bus.readdata); end
        applyStimulus(1'b0, 1'b1, 7'd6, 8'd0);
        checks++; if (bus.readdata !== 8'd0) begin errors++; $display("[TB] FAIL midrun_ctrl1 got=%h exp=00", bus.readdata); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
            checks++; if (clk_out !== '0 || tick !== '0) begin errors++; $display("[TB] FAIL midrun_idle got=%b/%b exp=0/0", clk_out, tick); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1;
        bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writedata = '0;
        tNow = 0;
        modelReset();
        $display("[TB] starting clock_divide_mc bench");
        test_reset();
        test_square();
        test_mode_switch();
        test_div_update();
        test_sync();
        test_idle_and_unmapped();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_divide_mc.md
Name: clock_divide_mc

Overview:
Multi-channel programmable clock divider. Each channel has a register-programmed divisor and produces a divided clock-enable waveform (clk_out) plus a one-cycle period tick. Host access is through a byte-wide address/writedata register bus. Adds per-channel enable, square/pulse mode, glitch-free divisor update at period boundaries, and a global phase-sync register.

Parameters:
NUM_CH, 4, number of divider channels (1..31)
DIV_W, 16, divisor/counter width in bits (2..16); bits above DIV_W are ignored on write and read back as 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
write  input  1  register write strobe, one cycle per access
read  input  1  register read strobe
address  input  7  register address
writedata  input  8  write data
readdata  output  8  read data, registered
clk_out  output  NUM_CH  divided output per channel, driven directly from a flop
tick  output  NUM_CH  one-cycle pulse at the start of each output period

Behaviour:
- Register map: channel c occupies address 4c+k, c < NUM_CH.
  - k=0 DIV_LO: write stages the low byte; reads the low byte of the shadow divisor.
  - k=1 DIV_HI: write commits {writedata, staged low} to the shadow divisor (prevents torn values); reads the high byte of the shadow.
  - k=2 CTRL: bit0 EN, bit1 MODE (0 = square, 1 = pulse); reads back.
  - k=3 STATUS: bit0 running (EN=1 and active divisor >= 2); read-only.
- 7'h7F SYNC: write-only; writedata bit i, i < NUM_CH and i < 8, restarts channel i. Reads return 0.
- Unmapped addresses: writes are ignored; reads return 0.
- readdata updates one cycle after a read strobe and holds until the next read. A read and a write to the same address in the same cycle return the pre-write value.
- Per-channel state: staging byte, shadow divisor, active divisor N, counter cnt, EN, MODE.
- Counting: while running, cnt steps 0, 1, ..., N-1, 0.
  - On the wrap (cnt == N-1), the next cycle has cnt = 0 and N loads from the shadow.
  - A shadow update mid-period never alters the current period.
- Output, for a cycle in which the counter holds value k:
  - MODE=0: clk_out = 1 iff k < ceil(N/2). Odd N gives (N+1)/2 cycles high and (N-1)/2 cycles low.
  - MODE=1: clk_out = 1 iff k == 0.
  - tick = 1 iff k == 0, in both modes.
- N < 2: channel is idle. cnt = 0, clk_out = 0, tick = 0, STATUS.running = 0. The channel starts on the first period boundary check after the shadow is loaded via enable or sync.
- EN 0 -> 1 write: the next cycle has cnt = 0, N loaded from the shadow, and tick/clk_out reflecting k = 0.
- EN 1 -> 0 write: the next cycle has cnt = 0, clk_out = 0, tick = 0. The shadow is retained.
- SYNC bit set on a running channel: same as a restart. The next cycle has cnt = 0 and N loaded from the shadow. Channels synced in the same write are phase-aligned from that cycle.
- SYNC on a disabled channel: no effect.
- CTRL write and SYNC to the same channel in one cycle is impossible (single bus). Back-to-back writes apply in order.
- MODE change while running: takes effect on the next cycle's output decode. The counter is not reset.
- Reset: all state cleared to 0.
  - Outputs: readdata = 0, clk_out = 0, tick = 0.
  - All channels idle; shadow = 0.
  - Reset mid-period aborts immediately and takes priority over a same-cycle write.

Test Plan:
- Ch0: write DIV_LO=4, DIV_HI=0, CTRL=1 -> clk_out[0] repeats 1,1,0,0; tick[0] every 4th cycle, aligned to the first 1; STATUS reads 1.
- Ch1: DIV=5, MODE=0 -> 3 cycles high, 2 low. Switch to MODE=1 -> single-cycle high every 5 cycles, no counter reset.
- Ch0 running at N=4: write DIV_LO=6/DIV_HI=0 at cnt=1 -> current period completes at 4 cycles, then the period is 6 (3 high, 3 low). A DIV_LO-only write -> no change.
- Ch0 N=4 and ch1 N=8 enabled at different times: write SYNC=8'h03 -> the next cycle has tick[0] = tick[1] = 1, then tick[1] coincides with every 2nd tick[0].
- DIV=1 or 0 with EN=1 -> clk_out = 0, tick = 0, STATUS = 0. Assert rst mid-run at N=4 -> next cycle all outputs 0 and CTRL readback 0.
- Read address 3 (STATUS) -> readdata valid exactly 1 cycle later. Read 7'h7F or address 4·NUM_CH -> 0. Write to an unmapped address -> no channel change.
